// File: rtl/nibble_serial_adder.sv
// Multi-cycle wide adder: one nibble per clock through a single 4-bit ripple-carry cell,
// with a registered carry loop and a start/busy/done handshake around the registered result.

module four_ripple_adder (
  output logic [4:0] s,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin
);

  logic [4:0] c;

  always_comb begin
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    s[4] = c[4];
  end

endmodule

module nibble_serial_adder #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [4*NIBBLES-1:0]   a_i,
  input  logic [4*NIBBLES-1:0]   b_i,
  input  logic                   cin_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [4*NIBBLES:0]     s_o
);

  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned CntW = (NIBBLES < 2) ? 1 : $clog2(NIBBLES + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [W-1:0]    acc_q, acc_d, acc_shift;
  logic [W:0]      s_q, s_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            carry_q, carry_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic            accept;
  logic [4:0]      cell_s;

  four_ripple_adder u_cell (
    .s   (cell_s),
    .a   (a_q[3:0]),
    .b   (b_q[3:0]),
    .cin (carry_q)
  );

  // New sum nibble enters from the top so nibble 0 lands in bits 3:0 after NIBBLES shifts.
  always_comb begin
    acc_shift          = acc_q >> 4;
    acc_shift[W-1 -: 4] = cell_s[3:0];
  end

  assign accept = start_i && ((state_q == StIdle) || (state_q == StDone));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;

    case (state_q)
      StRun: begin
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        carry_d = cell_s[4];
        cnt_d   = cnt_q + CntW'(1);
        acc_d   = acc_shift;
        if (cnt_q == CntW'(NIBBLES - 1)) begin
          s_d     = {cell_s[4], acc_shift};
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      StIdle:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Only reachable from IDLE/DONE, so it never collides with the RUN updates above.
    if (accept) begin
      a_d     = a_i;
      b_d     = b_i;
      carry_d = cin_i;
      cnt_d   = '0;
      state_d = StRun;
    end

    busy_d = (state_d == StRun);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign s_o    = s_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and random checks of nibble_serial_adder at NIBBLES=4 and NIBBLES=1.

module tb_nibble_serial_adder;

  logic        clk;
  logic        rst_n;

  logic        start4, cin4, busy4, done4;
  logic [15:0] a4, b4;
  logic [16:0] s4;

  logic        start1, cin1, busy1, done1;
  logic [3:0]  a1, b1;
  logic [4:0]  s1;

  int n_cmp;
  int n_bad;

  nibble_serial_adder #(.NIBBLES(4)) u_dut4 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start4),
    .a_i     (a4),
    .b_i     (b4),
    .cin_i   (cin4),
    .busy_o  (busy4),
    .done_o  (done4),
    .s_o     (s4)
  );

  nibble_serial_adder #(.NIBBLES(1)) u_dut1 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start1),
    .a_i     (a1),
    .b_i     (b1),
    .cin_i   (cin1),
    .busy_o  (busy1),
    .done_o  (done1),
    .s_o     (s1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [16:0] exp_s;
  } vec_t;

  vec_t tab[6];

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic busy_of(input bit w);
    return w ? busy4 : busy1;
  endfunction

  function automatic logic done_of(input bit w);
    return w ? done4 : done1;
  endfunction

  function automatic logic [16:0] s_of(input bit w);
    return w ? s4 : {12'd0, s1};
  endfunction

  task automatic drive(input bit w, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic st);
    if (w) begin
      start4 = st; a4 = a; b4 = b; cin4 = c;
    end else begin
      start1 = st; a1 = a[3:0]; b1 = b[3:0]; cin1 = c;
    end
  endtask

  // One complete operation with a single-cycle start; checks latency, hold and the done pulse.
  task automatic run_op(input bit w, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic [16:0] exp_s, input string name);
    int          cycles;
    int          nib;
    logic [16:0] prev;
    nib  = w ? 4 : 1;
    prev = s_of(w);
    @(negedge clk);
    drive(w, a, b, c, 1'b1);
    @(posedge clk); #1;
    check({name, "_accept_busy"}, 17'(busy_of(w)), 17'd1);
    drive(w, a, b, c, 1'b0);
    cycles = 0;
    while (!done_of(w) && cycles < 20) begin
      check({name, "_s_held"}, s_of(w), prev);
      @(posedge clk); #1;
      cycles++;
    end
    check({name, "_latency"}, 17'(cycles), 17'(nib));
    check({name, "_busy_at_done"}, 17'(busy_of(w)), 17'd0);
    check({name, "_sum"}, s_of(w), exp_s);
    @(posedge clk); #1;
    check({name, "_done_pulse"}, 17'(done_of(w)), 17'd0);
  endtask

  initial begin
    int          cycles;
    int          dones;
    logic [16:0] prev;
    logic [15:0] ra, rb;
    logic        rc;

    n_cmp = 0;
    n_bad = 0;
    tab[0] = '{16'h1234, 16'h4321, 1'b1, 17'h05556};
    tab[1] = '{16'hFFFF, 16'h0001, 1'b0, 17'h10000};
    tab[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF};
    tab[3] = '{16'h0000, 16'h0000, 1'b0, 17'h00000};
    tab[4] = '{16'h0F0F, 16'h00F1, 1'b0, 17'h01000};
    tab[5] = '{16'h8000, 16'h8000, 1'b1, 17'h10001};

    rst_n = 1'b0;
    drive(1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_busy4", 17'(busy4), 17'd0);
    check("reset_done4", 17'(done4), 17'd0);
    check("reset_s4", s4, 17'd0);
    check("reset_busy1", 17'(busy1), 17'd0);
    check("reset_done1", 17'(done1), 17'd0);
    check("reset_s1", {12'd0, s1}, 17'd0);

    for (int i = 0; i < 6; i++) begin
      run_op(1'b1, tab[i].a, tab[i].b, tab[i].cin, tab[i].exp_s, $sformatf("vec%0d", i));
    end

    // Start held through RUN (including the final edge) with changing junk operands.
    prev = s4;
    @(negedge clk);
    drive(1'b1, 16'h1234, 16'h4321, 1'b1, 1'b1);
    @(posedge clk); #1;
    cycles = 0;
    while (!done4 && cycles < 20) begin
      drive(1'b1, 16'hFFFF - 16'(cycles), 16'hA5A5 + 16'(cycles), cycles[0], 1'b1);
      check("ign_s_held", s4, prev);
      @(posedge clk); #1;
      cycles++;
    end
    drive(1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
    check("ign_latency", 17'(cycles), 17'd4);
    check("ign_sum", s4, 17'h05556);
    dones = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done4) dones++;
    end
    check("ign_extra_done", 17'(dones), 17'd0);
    check("ign_idle_busy", 17'(busy4), 17'd0);

    // Back-to-back: start held across two operations.
    @(negedge clk);
    drive(1'b1, 16'h0001, 16'h0002, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b1);
    cycles = 0;
    while (!done4 && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
    check("b2b_lat1", 17'(cycles), 17'd4);
    check("b2b_sum1", s4, 17'h00003);
    cycles = 0;
    @(posedge clk); #1;
    cycles++;
    check("b2b_reaccept_busy", 17'(busy4), 17'd1);
    drive(1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
    while (!done4 && cycles < 20) begin
      check("b2b_s_held", s4, 17'h00003);
      @(posedge clk); #1;
      cycles++;
    end
    check("b2b_spacing", 17'(cycles), 17'd5);
    check("b2b_sum2", s4, 17'h10000);

    // Reset two cycles into RUN.
    @(negedge clk);
    drive(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_busy", 17'(busy4), 17'd0);
    check("rst_done", 17'(done4), 17'd0);
    check("rst_s", s4, 17'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done4) dones++;
    end
    check("rst_no_done", 17'(dones), 17'd0);
    check("rst_s_stays", s4, 17'd0);
    run_op(1'b1, 16'h1111, 16'h2222, 1'b1, 17'h03334, "post_rst");

    run_op(1'b0, 16'hF, 16'hF, 1'b1, 17'h1F, "n1_max");
    run_op(1'b0, 16'h0, 16'h0, 1'b0, 17'h00, "n1_zero");

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      run_op(1'b1, ra, rb, rc, 17'(ra) + 17'(rb) + 17'(rc), "rnd4");
    end
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom_range(0, 15));
      rb = 16'($urandom_range(0, 15));
      rc = 1'($urandom);
      run_op(1'b0, ra, rb, rc, 17'(ra) + 17'(rb) + 17'(rc), "rnd1");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle wide adder that adds two `4*NIBBLES`-bit operands one nibble per clock. It uses a single instance of the team's 4-bit ripple-carry cell `four_ripple_adder` (ports `s[4:0]`, `a[3:0]`, `b[3:0]`, `cin`). The block sits directly around that cell:
- It sequences operand nibbles into the cell's `a`/`b`.
- It registers the cell's carry-out `s[4]` and feeds it back into the cell's `cin` on the next cycle.
- It assembles the sum nibbles into a registered wide result with a start/done handshake.

## Interface

- `NIBBLES`, default 4: number of 4-bit digits per operand; operand width `W = 4*NIBBLES`; legal range ≥ 1.

- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request a new addition; sampled only when not busy.
- `a`  input  W  operand A; sampled on the accepting edge only.
- `b`  input  W  operand B; sampled on the accepting edge only.
- `cin`  input  1  carry into nibble 0; sampled on the accepting edge only.
- `busy`  output  1  high while nibbles are being processed.
- `done`  output  1  one-cycle pulse: `s` has just been updated with a new result.
- `s`  output  W+1  registered result; `s[W-1:0]` is the sum, `s[W]` is the final carry.

## Operation

- States: `IDLE`, `RUN`, `DONE`.
  - `IDLE` is entered on reset.
  - `DONE` lasts exactly one cycle.
- Accept: `start`=1 at an edge while in `IDLE` or `DONE`. On that edge:
  - latch `a` and `b` into internal shift registers;
  - carry register ← `cin`;
  - nibble counter ← 0;
  - state ← `RUN`.
- `start` is ignored in `RUN`. Operands and `cin` are not re-sampled while in `RUN`.
- `RUN`, each cycle:
  - The cell adds the low nibbles of the A/B shift registers plus the carry register.
  - At the edge: sum nibble `s_cell[3:0]` shifts into the result register from the top (LSB nibble ends at bits 3:0 after `NIBBLES` shifts).
  - At the edge: carry register ← `s_cell[4]`; A/B registers shift right by 4; counter increments.
- After the `NIBBLES`-th `RUN` edge:
  - output `s` ← {final carry, assembled sum};
  - `done` ← 1;
  - state ← `DONE`.
- `DONE` → `IDLE` on the next edge, unless `start`=1, in which case a new operation is accepted (back-to-back).
- Output behaviour:
  - `s` is updated only on the edge entering `DONE`, and holds its value otherwise, including throughout a following `RUN`.
  - `busy` = (state == `RUN`), registered.
  - `done` = (state == `DONE`), registered.
- Arithmetic: result = `a + b + cin` exactly, modulo 2^(W+1); no overflow is possible in W+1 bits.
- Counter width: ceil(log2(NIBBLES+1)), minimum 1.

## Timing

- Reset values (asynchronous, immediate on `rst_n`=0):
  - state `IDLE`, `busy`=0, `done`=0, `s`=0;
  - operand, result, carry and counter registers all 0.
- Reset in `RUN` aborts the operation: no `done`, and `s` returns to 0.
- Latency, with the start accepted at edge k:
  - `busy`=1 from edge k to edge k+NIBBLES;
  - `done`=1 and new `s` valid from edge k+NIBBLES to edge k+NIBBLES+1.
- Throughput: one result per NIBBLES+1 cycles when `start` is held high continuously.
- `NIBBLES`=1: one `RUN` cycle; `done` follows the accepting edge by exactly 1 cycle.
- Simultaneous events:
  - `start` in `DONE` takes priority over the return to `IDLE`.
  - `start` during `RUN`, including on the final `RUN` edge, is dropped and not queued.
- There is no combinational path from any input to any output.

## Test plan

- After reset release, all outputs are 0. With `NIBBLES`=4, `a`=0x1234, `b`=0x4321, `cin`=1, 1-cycle `start`:
  - `busy` high for 4 cycles;
  - then `done` pulses once with `s`=0x05556.
- Full carry ripple across all nibbles: `a`=0xFFFF, `b`=0x0001, `cin`=0 → `s`=0x10000 on `done`. Then `a`=0xFFFF, `b`=0xFFFF, `cin`=1 → `s`=0x1FFFF.
- Ignored start: during `RUN`, pulse `start` with different operands and toggle `a`/`b`/`cin` → no effect:
  - the original result is produced;
  - exactly one `done`;
  - `s` unchanged until that `done`.
- Back-to-back: hold `start`=1 for two operations (0x0001+0x0002+0, then 0x8000+0x8000+0) → `done` pulses 5 cycles apart with `s`=0x00003 then `s`=0x10000.
- Reset mid-operation: assert `rst_n`=0 two cycles into `RUN` → `busy`, `done` and `s` go to 0 immediately, and no `done` follows. A new start after release then completes correctly.
- Random sweep at `NIBBLES`=1 and `NIBBLES`=4, including `NIBBLES`=1 with 0xF+0xF+1 → `s`=0x1F one cycle after accept. Each result is compared against `a+b+cin` over 1000 operations.
